// File: rtl/motor_ramp_driver.sv
// motor_ramp_driver
// Turns the 3-bit direction code from the direction FSM into H-bridge drive:
// a soft-start/soft-stop PWM duty ramp, polarity pins, and a coast period
// that every polarity reversal must pass through.
module motor_ramp_driver #(
    parameter int PWM_BITS         = 8,
    parameter int MAX_DUTY         = 200,
    parameter int RAMP_STEP_CYCLES = 50000,
    parameter int DEAD_CYCLES      = 5000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          direction,
    output logic                motor_pwm,
    output logic                motor_in1,
    output logic                motor_in2,
    output logic [PWM_BITS-1:0] duty,
    output logic                busy
);

    // One counter serves both the ramp step timer and the dead-time timer,
    // so it is sized for whichever of the two is longer.
    localparam int CNT_LIMIT = (DEAD_CYCLES > RAMP_STEP_CYCLES) ? DEAD_CYCLES : RAMP_STEP_CYCLES;
    localparam int CNT_W     = (CNT_LIMIT > 1) ? $clog2(CNT_LIMIT) : 1;

    localparam logic [CNT_W-1:0]    STEP_LAST    = CNT_W'(RAMP_STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0]    DEAD_LAST    = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX     = PWM_BITS'(MAX_DUTY);
    localparam logic [PWM_BITS-1:0] DUTY_PRE_MAX = PWM_BITS'(MAX_DUTY - 1);
    localparam logic [PWM_BITS-1:0] DUTY_ZERO    = '0;
    localparam logic [PWM_BITS-1:0] DUTY_ONE     = PWM_BITS'(1);

    // Direction codes that request motion; every other code means stop.
    localparam logic [2:0] DIR_FWD = 3'd1;
    localparam logic [2:0] DIR_BWD = 3'd3;

    typedef enum logic [2:0] {
        ST_STOPPED,
        ST_RAMP_UP,
        ST_RUN,
        ST_RAMP_DOWN,
        ST_DEAD
    } state_t;

    state_t                state_q,   state_d;
    logic [2:0]            dir_q;
    logic [PWM_BITS-1:0]   duty_q,    duty_d;
    logic                  rev_q,     rev_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [PWM_BITS-1:0]   pwm_cnt_q;
    logic                  pwm_q,     pwm_d;
    logic                  in1_q,     in1_d;
    logic                  in2_q,     in2_d;

    // Decoded target, always taken from the registered direction code.
    logic run_tgt;
    logic tgt_rev;
    logic hold_tgt;
    logic step_hit;
    logic dead_done;

    assign run_tgt   = (dir_q == DIR_FWD) || (dir_q == DIR_BWD);
    assign tgt_rev   = (dir_q == DIR_BWD);
    // Target asks to keep running with the polarity already latched.
    assign hold_tgt  = run_tgt && (tgt_rev == rev_q);
    assign step_hit  = (cnt_q == STEP_LAST);
    assign dead_done = (cnt_q == DEAD_LAST);

    // Register the incoming direction code once before it is decoded.
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values; a blocking = here would let later statements see
    // already-updated values and break the register chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q <= 3'd0;
        end else begin
            dir_q <= direction;
        end
    end

    // Next-state, duty and polarity decisions for the ramp controller.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        rev_d   = rev_q;

        case (state_q)
            ST_STOPPED: begin
                if (run_tgt) begin
                    rev_d   = tgt_rev;
                    state_d = ST_RAMP_UP;
                end
            end

            ST_RAMP_UP: begin
                if (!hold_tgt) begin
                    // Stop or opposite polarity: begin slowing from the current duty.
                    state_d = ST_RAMP_DOWN;
                end else if (duty_q >= DUTY_MAX) begin
                    // Re-entered from a ramp-down that had not yet stepped.
                    state_d = ST_RUN;
                end else if (step_hit) begin
                    duty_d = duty_q + DUTY_ONE;
                    if (duty_q == DUTY_PRE_MAX) begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (!hold_tgt) begin
                    state_d = ST_RAMP_DOWN;
                end
            end

            ST_RAMP_DOWN: begin
                if (hold_tgt) begin
                    // Same polarity requested again: climb back without coasting.
                    state_d = ST_RAMP_UP;
                end else if (duty_q == DUTY_ZERO) begin
                    state_d = ST_DEAD;
                end else if (step_hit) begin
                    duty_d = duty_q - DUTY_ONE;
                    if (duty_q == DUTY_ONE) begin
                        state_d = ST_DEAD;
                    end
                end
            end

            ST_DEAD: begin
                // Target is deliberately ignored until the coast time expires.
                if (dead_done) begin
                    state_d = ST_STOPPED;
                end
            end

            default: begin
                state_d = ST_STOPPED;
                duty_d  = DUTY_ZERO;
            end
        endcase
    end

    // Step / dead-time counter: cleared on every state entry and after each duty step.
    always_comb begin
        cnt_d = '0;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN)) begin
            cnt_d = step_hit ? '0 : cnt_q + CNT_W'(1);
        end else if (state_q == ST_DEAD) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Polarity pins follow the next state so they switch on the same edge as it.
    always_comb begin
        logic active_d;
        active_d = (state_d == ST_RAMP_UP) || (state_d == ST_RUN) || (state_d == ST_RAMP_DOWN);
        in1_d    = active_d && !rev_d;
        in2_d    = active_d &&  rev_d;
    end

    // PWM compare of the free-running counter against the current duty.
    assign pwm_d = (pwm_cnt_q < duty_q);

    // Controller state, duty, polarity and pin registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_STOPPED;
            duty_q  <= DUTY_ZERO;
            rev_q   <= 1'b0;
            cnt_q   <= '0;
            in1_q   <= 1'b0;
            in2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            rev_q   <= rev_d;
            cnt_q   <= cnt_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
        end
    end

    // Free-running PWM counter with natural wrap and registered PWM output.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            pwm_q     <= pwm_d;
        end
    end

    assign motor_pwm = pwm_q;
    assign motor_in1 = in1_q;
    assign motor_in2 = in2_q;
    assign duty      = duty_q;
    assign busy      = (state_q != ST_STOPPED);

endmodule

// File: tb/tb_motor_ramp_driver.sv
// tb_motor_ramp_driver
// Directed scenarios with timing derived from the ramp rules, plus a long
// randomized direction sequence checked every cycle against a behavioural model.
module tb_motor_ramp_driver;

    localparam int PWM_BITS = 4;
    localparam int MAX_DUTY = 10;
    localparam int RAMP     = 4;
    localparam int DEAD     = 20;
    localparam int PERIOD   = 1 << PWM_BITS;

    logic                clk;
    logic                reset;
    logic [2:0]          direction;
    logic                motor_pwm;
    logic                motor_in1;
    logic                motor_in2;
    logic [PWM_BITS-1:0] duty;
    logic                busy;

    int n_checks;
    int n_errors;
    bit mon_en;

    motor_ramp_driver #(
        .PWM_BITS        (PWM_BITS),
        .MAX_DUTY        (MAX_DUTY),
        .RAMP_STEP_CYCLES(RAMP),
        .DEAD_CYCLES     (DEAD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .direction(direction),
        .motor_pwm(motor_pwm),
        .motor_in1(motor_in1),
        .motor_in2(motor_in2),
        .duty     (duty),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural reference: phases with elapsed-time bookkeeping.
    // ------------------------------------------------------------------
    localparam int P_IDLE = 0;
    localparam int P_UP   = 1;
    localparam int P_RUN  = 2;
    localparam int P_DOWN = 3;
    localparam int P_DEAD = 4;

    int m_phase, m_duty, m_rev, m_elapsed, m_pcnt, m_dir_seen;
    bit m_pwm, m_in1, m_in2;

    always @(posedge clk) begin
        int  prev_phase;
        bit  want_run, want_rev, keep, tick;
        if (reset) begin
            m_phase = P_IDLE; m_duty = 0; m_rev = 0; m_elapsed = 0;
            m_pcnt = 0; m_dir_seen = 0; m_pwm = 0; m_in1 = 0; m_in2 = 0;
        end else begin
            m_pwm  = ((m_pcnt % PERIOD) < m_duty);
            m_pcnt = (m_pcnt + 1) % PERIOD;
            want_run   = (m_dir_seen == 1) || (m_dir_seen == 3);
            want_rev   = (m_dir_seen == 3);
            keep       = want_run && (want_rev == m_rev);
            tick       = (m_elapsed % RAMP) == (RAMP - 1);
            prev_phase = m_phase;
            case (m_phase)
                P_IDLE: if (want_run) begin m_rev = want_rev; m_phase = P_UP; end
                P_UP: begin
                    if (!keep) m_phase = P_DOWN;
                    else if (m_duty >= MAX_DUTY) m_phase = P_RUN;
                    else if (tick) begin
                        m_duty++;
                        if (m_duty == MAX_DUTY) m_phase = P_RUN;
                    end
                end
                P_RUN: if (!keep) m_phase = P_DOWN;
                P_DOWN: begin
                    if (keep) m_phase = P_UP;
                    else if (m_duty == 0) m_phase = P_DEAD;
                    else if (tick) begin
                        m_duty--;
                        if (m_duty == 0) m_phase = P_DEAD;
                    end
                end
                default: if (m_elapsed == DEAD - 1) m_phase = P_IDLE;
            endcase
            m_elapsed = (m_phase != prev_phase) ? 0 : m_elapsed + 1;
            m_in1 = (m_phase != P_IDLE) && (m_phase != P_DEAD) && (m_rev == 0);
            m_in2 = (m_phase != P_IDLE) && (m_phase != P_DEAD) && (m_rev == 1);
            m_dir_seen = int'(direction);
        end
    end

    // Cycle-by-cycle comparison of every output against the reference.
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (motor_pwm !== m_pwm || motor_in1 !== m_in1 || motor_in2 !== m_in2 ||
                duty !== 4'(m_duty) || busy !== (m_phase != P_IDLE)) begin
                n_errors++;
                $display("FAIL model_compare t=%0t: got pwm=%b in1=%b in2=%b duty=%0d busy=%b, expected pwm=%b in1=%b in2=%b duty=%0d busy=%b",
                         $time, motor_pwm, motor_in1, motor_in2, duty, busy,
                         m_pwm, m_in1, m_in2, m_duty, (m_phase != P_IDLE));
            end
        end
    end

    // Global guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Synchronous reset pulse; leaves the bench at a negedge with reset low.
    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        direction = 3'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        mon_en = 1'b1;
        n_checks++;
        if (duty !== 4'd0 || motor_pwm !== 1'b0 || motor_in1 !== 1'b0 ||
            motor_in2 !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: got duty=%0d pwm=%b in1=%b in2=%b busy=%b, expected all 0",
                     duty, motor_pwm, motor_in1, motor_in2, busy);
        end
    endtask

    task automatic test_idle_hold();
        direction = 3'd0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            n_checks++;
            if (duty !== 4'd0 || motor_pwm !== 1'b0 || motor_in1 !== 1'b0 ||
                motor_in2 !== 1'b0 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL idle_hold cycle %0d: got duty=%0d pwm=%b in1=%b in2=%b busy=%b, expected all 0",
                         k, duty, motor_pwm, motor_in1, motor_in2, busy);
            end
        end
    endtask

    // 0 -> 1: pins two edges later, duty steps every RAMP cycles up to MAX_DUTY.
    task automatic test_forward_ramp();
        int exp_duty;
        int highs;
        logic exp_in1;
        do_reset();
        direction = 3'd1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            exp_duty = (k < 2 + RAMP) ? 0 : (k - 2) / RAMP;
            if (exp_duty > MAX_DUTY) exp_duty = MAX_DUTY;
            exp_in1 = (k >= 2);
            n_checks++;
            if (duty !== exp_duty[3:0] || motor_in1 !== exp_in1 || motor_in2 !== 1'b0) begin
                n_errors++;
                $display("FAIL forward_ramp edge %0d: got duty=%0d in1=%b in2=%b, expected duty=%0d in1=%b in2=0",
                         k, duty, motor_in1, motor_in2, exp_duty, exp_in1);
            end
        end
        highs = 0;
        for (int k = 0; k < PERIOD; k++) begin
            @(negedge clk);
            if (motor_pwm === 1'b1) highs++;
        end
        n_checks++;
        if (highs != MAX_DUTY) begin
            n_errors++;
            $display("FAIL run_pwm_ratio: got %0d high cycles per %0d, expected %0d", highs, PERIOD, MAX_DUTY);
        end
    endtask

    // RUN forwards -> 3: ramp down, full dead time, then ramp up backwards.
    task automatic test_reversal();
        int exp_duty, dead_len;
        logic exp_in1, exp_in2, exp_busy;
        direction = 3'd3;
        dead_len  = 0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (k < 42) exp_duty = (k < 2 + RAMP) ? MAX_DUTY : MAX_DUTY - (k - 2) / RAMP;
            else        exp_duty = (k >= 67) ? 1 : 0;
            exp_in1  = (k < 42);
            exp_in2  = (k >= 63);
            exp_busy = (k != 62);
            if (busy && !motor_in1 && !motor_in2) dead_len++;
            n_checks++;
            if (duty !== exp_duty[3:0] || motor_in1 !== exp_in1 || motor_in2 !== exp_in2 ||
                busy !== exp_busy || (motor_in1 && motor_in2)) begin
                n_errors++;
                $display("FAIL reversal edge %0d: got duty=%0d in1=%b in2=%b busy=%b, expected duty=%0d in1=%b in2=%b busy=%b",
                         k, duty, motor_in1, motor_in2, busy, exp_duty, exp_in1, exp_in2, exp_busy);
            end
        end
        n_checks++;
        if (dead_len != DEAD) begin
            n_errors++;
            $display("FAIL reversal_dead_len: got %0d cycles, expected %0d", dead_len, DEAD);
        end
    endtask

    // Ramp down to duty 5 on a stop code, then resume forwards without coasting.
    task automatic test_ramp_down_recover();
        int exp_duty;
        do_reset();
        direction = 3'd1;
        repeat (45) @(negedge clk);
        direction = 3'd4;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            exp_duty = (k < 2 + RAMP) ? MAX_DUTY : MAX_DUTY - (k - 2) / RAMP;
            n_checks++;
            if (duty !== exp_duty[3:0] || motor_in1 !== 1'b1) begin
                n_errors++;
                $display("FAIL recover_down edge %0d: got duty=%0d in1=%b, expected duty=%0d in1=1",
                         k, duty, motor_in1, exp_duty);
            end
        end
        direction = 3'd1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            exp_duty = (k < 2 + RAMP) ? 5 : 5 + (k - 2) / RAMP;
            if (exp_duty > MAX_DUTY) exp_duty = MAX_DUTY;
            n_checks++;
            if (duty !== exp_duty[3:0] || motor_in1 !== 1'b1 || motor_in2 !== 1'b0 || busy !== 1'b1) begin
                n_errors++;
                $display("FAIL recover_up edge %0d: got duty=%0d in1=%b in2=%b busy=%b, expected duty=%0d in1=1 in2=0 busy=1",
                         k, duty, motor_in1, motor_in2, busy, exp_duty);
            end
        end
    endtask

    // Direction toggles during DEAD must not shorten or extend the coast.
    task automatic test_dead_toggle();
        int dead_len;
        do_reset();
        direction = 3'd1;
        repeat (45) @(negedge clk);
        direction = 3'd3;
        dead_len  = 0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (k == 45) direction = 3'd1;
            if (k == 50) direction = 3'd3;
            if (busy && !motor_in1 && !motor_in2) dead_len++;
            if (k == 62) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL dead_toggle_stopped: got busy=%b, expected 0", busy);
                end
            end
            if (k == 63 || k == 70) begin
                n_checks++;
                if (motor_in1 !== 1'b0 || motor_in2 !== 1'b1) begin
                    n_errors++;
                    $display("FAIL dead_toggle_polarity edge %0d: got in1=%b in2=%b, expected in1=0 in2=1",
                             k, motor_in1, motor_in2);
                end
            end
        end
        n_checks++;
        if (dead_len != DEAD) begin
            n_errors++;
            $display("FAIL dead_toggle_len: got %0d cycles, expected %0d", dead_len, DEAD);
        end
    endtask

    // Reset mid-ramp, then an out-of-range code must not start the motor.
    task automatic test_reset_mid_ramp();
        int waited;
        do_reset();
        direction = 3'd1;
        waited    = 0;
        while (duty !== 4'd6 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (duty !== 4'd6) begin
            n_errors++;
            $display("FAIL mid_ramp_wait: got duty=%0d after %0d cycles, expected 6", duty, waited);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (duty !== 4'd0 || motor_pwm !== 1'b0 || motor_in1 !== 1'b0 ||
            motor_in2 !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_ramp_reset: got duty=%0d pwm=%b in1=%b in2=%b busy=%b, expected all 0",
                     duty, motor_pwm, motor_in1, motor_in2, busy);
        end
        reset     = 1'b0;
        direction = 3'd5;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || duty !== 4'd0 || motor_in1 !== 1'b0 || motor_in2 !== 1'b0) begin
                n_errors++;
                $display("FAIL code5_stays_stopped cycle %0d: got busy=%b duty=%0d in1=%b in2=%b, expected all 0",
                         k, busy, duty, motor_in1, motor_in2);
            end
        end
    endtask

    // Random direction codes and hold times, with occasional resets; the
    // monitor compares every cycle against the reference.
    task automatic test_random();
        int sel, hold;
        do_reset();
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: direction = 3'd1;
                3, 4, 5: direction = 3'd3;
                default: direction = 3'($urandom_range(0, 7));
            endcase
            if ($urandom_range(0, 40) == 0) reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            hold  = $urandom_range(1, 60);
            repeat (hold) @(negedge clk);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        mon_en    = 1'b0;
        reset     = 1'b1;
        direction = 3'd0;
        test_reset();
        test_idle_hold();
        test_forward_ramp();
        test_reversal();
        test_ramp_down_recover();
        test_dead_toggle();
        test_reset_mid_ramp();
        test_random();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
